// File: rtl/lcd_ctrl_pkg.sv
// ============================================================================
// Module   : lcd_ctrl_pkg
// Purpose  : Shared opcodes, FSM state type and geometry helpers for the
//            LCD image controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE = 4'h0;
    localparam logic [3:0] CMD_UP    = 4'h1;
    localparam logic [3:0] CMD_DOWN  = 4'h2;
    localparam logic [3:0] CMD_LEFT  = 4'h3;
    localparam logic [3:0] CMD_RIGHT = 4'h4;
    localparam logic [3:0] CMD_MAX   = 4'h5;
    localparam logic [3:0] CMD_MIN   = 4'h6;
    localparam logic [3:0] CMD_AVG   = 4'h7;
    localparam logic [3:0] CMD_CCW   = 4'h8;
    localparam logic [3:0] CMD_CW    = 4'h9;
    localparam logic [3:0] CMD_MIRX  = 4'hA;
    localparam logic [3:0] CMD_MIRY  = 4'hB;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_LOAD_LAST = 3'd1,
        ST_IDLE      = 3'd2,
        ST_OP        = 3'd3,
        ST_WRITE     = 3'd4
    } state_t;

    function automatic int lcd_pixels(input int w, input int h);
        return w * h;
    endfunction

    function automatic int lcd_addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_window_alu.sv
// ============================================================================
// Module   : lcd_window_alu
// Purpose  : Combinational 2x2 window transform (max/min/avg/rotate/mirror).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_window_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] tl,
    input  logic [DATA_W-1:0] tr,
    input  logic [DATA_W-1:0] bl,
    input  logic [DATA_W-1:0] br,
    output logic [DATA_W-1:0] new_tl,
    output logic [DATA_W-1:0] new_tr,
    output logic [DATA_W-1:0] new_bl,
    output logic [DATA_W-1:0] new_br
);

    logic [DATA_W+1:0] sum;
    logic [DATA_W-1:0] top_max;
    logic [DATA_W-1:0] bot_max;
    logic [DATA_W-1:0] top_min;
    logic [DATA_W-1:0] bot_min;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_avg;

    // Two guard bits keep the four-pixel sum exact.
    assign sum     = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    assign win_avg = DATA_W'(sum >> 2);

    assign top_max = (tl > tr) ? tl : tr;
    assign bot_max = (bl > br) ? bl : br;
    assign win_max = (top_max > bot_max) ? top_max : bot_max;
    assign top_min = (tl < tr) ? tl : tr;
    assign bot_min = (bl < br) ? bl : br;
    assign win_min = (top_min < bot_min) ? top_min : bot_min;

    always_comb begin
        new_tl = tl;
        new_tr = tr;
        new_bl = bl;
        new_br = br;
        case (op)
            CMD_MAX: begin
                new_tl = win_max;
                new_tr = win_max;
                new_bl = win_max;
                new_br = win_max;
            end
            CMD_MIN: begin
                new_tl = win_min;
                new_tr = win_min;
                new_bl = win_min;
                new_br = win_min;
            end
            CMD_AVG: begin
                new_tl = win_avg;
                new_tr = win_avg;
                new_bl = win_avg;
                new_br = win_avg;
            end
            CMD_CCW: begin
                new_tl = tr;
                new_tr = br;
                new_br = bl;
                new_bl = tl;
            end
            CMD_CW: begin
                new_tl = bl;
                new_bl = br;
                new_br = tr;
                new_tr = tl;
            end
            CMD_MIRX: begin
                new_tl = bl;
                new_bl = tl;
                new_tr = br;
                new_br = tr;
            end
            CMD_MIRY: begin
                new_tl = tr;
                new_tr = tl;
                new_bl = br;
                new_br = bl;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl_param.sv
// ============================================================================
// Module   : lcd_ctrl_param
// Purpose  : Loads a frame from IROM, applies 2x2 window commands and streams
//            the frame buffer to IRAM on request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = lcd_addr_w(IMG_W, IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] IROM_Q,
    output logic              IROM_rd,
    output logic [ADDR_W-1:0] IROM_A,
    output logic              IRAM_valid,
    output logic [DATA_W-1:0] IRAM_D,
    output logic [ADDR_W-1:0] IRAM_A,
    output logic              busy,
    output logic              done
);

    localparam int                N      = lcd_pixels(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] X_MAX  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_MAX  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] OX_RST = ADDR_W'(IMG_W / 2 - 1);
    localparam logic [ADDR_W-1:0] OY_RST = ADDR_W'(IMG_H / 2 - 1);
    localparam logic [ADDR_W-1:0] ROW    = ADDR_W'(IMG_W);

    state_t            state;
    logic [3:0]        op;
    logic [ADDR_W-1:0] ox;
    logic [ADDR_W-1:0] oy;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_valid;
    logic [DATA_W-1:0] pix_buf [N];

    logic [ADDR_W-1:0] a_tl;
    logic [ADDR_W-1:0] a_tr;
    logic [ADDR_W-1:0] a_bl;
    logic [ADDR_W-1:0] a_br;
    logic [ADDR_W-1:0] ram_a_next;
    logic [DATA_W-1:0] new_tl;
    logic [DATA_W-1:0] new_tr;
    logic [DATA_W-1:0] new_bl;
    logic [DATA_W-1:0] new_br;

    assign a_tl       = oy * ROW + ox;
    assign a_tr       = a_tl + 1'b1;
    assign a_bl       = a_tl + ROW;
    assign a_br       = a_bl + 1'b1;
    assign ram_a_next = IRAM_A + 1'b1;

    lcd_window_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .tl     (pix_buf[a_tl]),
        .tr     (pix_buf[a_tr]),
        .bl     (pix_buf[a_bl]),
        .br     (pix_buf[a_br]),
        .new_tl (new_tl),
        .new_tr (new_tr),
        .new_bl (new_bl),
        .new_br (new_br)
    );

    // ROM data lags its address by one cycle, so the capture address is the
    // address that was presented two edges ago.
    always_ff @(posedge clk) begin
        if (cap_valid) begin
            pix_buf[cap_addr] <= IROM_Q;
        end else if (state == ST_OP) begin
            pix_buf[a_tl] <= new_tl;
            pix_buf[a_tr] <= new_tr;
            pix_buf[a_bl] <= new_bl;
            pix_buf[a_br] <= new_br;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
            IRAM_D     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            op         <= CMD_WRITE;
            ox         <= OX_RST;
            oy         <= OY_RST;
            cap_addr   <= '0;
            cap_valid  <= 1'b0;
        end else begin
            cap_addr  <= IROM_A;
            cap_valid <= IROM_rd;
            done      <= 1'b0;
            case (state)
                ST_LOAD: begin
                    IROM_rd <= 1'b1;
                    if (IROM_rd) begin
                        if (IROM_A == LAST_A) begin
                            IROM_rd <= 1'b0;
                            state   <= ST_LOAD_LAST;
                        end else begin
                            IROM_A <= IROM_A + 1'b1;
                        end
                    end
                end
                ST_LOAD_LAST: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        op   <= cmd;
                        if (cmd == CMD_WRITE) begin
                            state      <= ST_WRITE;
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= pix_buf[0];
                        end else begin
                            state <= ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    case (op)
                        CMD_UP:    if (oy != '0)   oy <= oy - 1'b1;
                        CMD_DOWN:  if (oy < Y_MAX) oy <= oy + 1'b1;
                        CMD_LEFT:  if (ox != '0)   ox <= ox - 1'b1;
                        CMD_RIGHT: if (ox < X_MAX) ox <= ox + 1'b1;
                        default: ;
                    endcase
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_WRITE: begin
                    // A WRITE cycle with valid low is the done cycle.
                    if (IRAM_valid) begin
                        if (IRAM_A == LAST_A) begin
                            IRAM_valid <= 1'b0;
                            IRAM_A     <= '0;
                            done       <= 1'b1;
                        end else begin
                            IRAM_A <= ram_a_next;
                            IRAM_D <= pix_buf[ram_a_next];
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl_param.sv
// ============================================================================
// Module   : tb_lcd_ctrl_param
// Purpose  : Randomised, model-checked bench for lcd_ctrl_param (8x8 and 4x4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl_param;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int N2 = 16;

    typedef struct {
        int busy;
        int done;
        int wv;
        int rd;
        int rom_a;
        int ram_a;
        int ram_d;
    } rec_t;

    logic       clk;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] IROM_Q;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic       IRAM_valid;
    logic [7:0] IRAM_D;
    logic [5:0] IRAM_A;
    logic       busy;
    logic       done;

    logic        reset2;
    logic [3:0]  cmd2;
    logic        cmd_valid2;
    logic [11:0] IROM_Q2;
    logic        IROM_rd2;
    logic [3:0]  IROM_A2;
    logic        IRAM_valid2;
    logic [11:0] IRAM_D2;
    logic [3:0]  IRAM_A2;
    logic        busy2;
    logic        done2;

    int   total;
    int   bad;
    rec_t exp_q[$];
    rec_t cur;
    logic [7:0] rom [N];
    int   img [N];
    int   ram [N];
    int   ram2 [N2];
    int   wr2;
    int   ox;
    int   oy;

    lcd_ctrl_param #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
        .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.DATA_W(12), .IMG_W(4), .IMG_H(4)) dut_small (
        .clk(clk), .reset(reset2), .cmd(cmd2), .cmd_valid(cmd_valid2),
        .IROM_Q(IROM_Q2), .IROM_rd(IROM_rd2), .IROM_A(IROM_A2),
        .IRAM_valid(IRAM_valid2), .IRAM_D(IRAM_D2), .IRAM_A(IRAM_A2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROMs answer with one cycle of latency; RAM sinks record every write.
    always @(posedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];
    always @(posedge clk) if (IROM_rd2) IROM_Q2 <= 12'(IROM_A2);
    always @(negedge clk) if (IRAM_valid) ram[IRAM_A] <= int'(IRAM_D);
    always @(negedge clk) begin
        if (IRAM_valid2) begin
            ram2[IRAM_A2] <= int'(IRAM_D2);
            wr2 <= wr2 + 1;
        end
    end

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic rec_t mk(int b, int d, int wv, int rd, int ra, int wa, int wd);
        rec_t r;
        r.busy = b; r.done = d; r.wv = wv; r.rd = rd;
        r.rom_a = ra; r.ram_a = wa; r.ram_d = wd;
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("busy", int'(busy), cur.busy);
            chk("done", int'(done), cur.done);
            chk("iram_valid", int'(IRAM_valid), cur.wv);
            chk("irom_rd", int'(IROM_rd), cur.rd);
            if (cur.rom_a >= 0) chk("irom_a", int'(IROM_A), cur.rom_a);
            if (cur.ram_a >= 0) chk("iram_a", int'(IRAM_A), cur.ram_a);
            if (cur.ram_d >= 0) chk("iram_d", int'(IRAM_D), cur.ram_d);
        end
    end

    // Inputs are applied just after a falling edge; the record describes the
    // outputs expected at the following falling edge.
    task automatic step(rec_t r, logic v, logic [3:0] c);
        cmd_valid = v;
        cmd       = c;
        exp_q.push_back(r);
        @(negedge clk);
        #1;
    endtask

    task automatic step_n(rec_t r);
        step(r, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    endtask

    task automatic idle_cycle();
        step(mk(0, 0, 0, 0, -1, -1, -1), 1'b0, 4'h0);
    endtask

    task automatic reset_load();
        reset = 1'b0;
        repeat (2) step(mk(1, 0, 0, 0, 0, 0, 0), 1'b0, 4'h0);
        reset = 1'b1;
        for (int c = 1; c <= N; c++) step_n(mk(1, 0, 0, 1, c - 1, -1, -1));
        step_n(mk(1, 0, 0, 0, -1, -1, -1));
        step_n(mk(0, 0, 0, 0, -1, -1, -1));
        for (int i = 0; i < N; i++) img[i] = int'(rom[i]);
        ox = W / 2 - 1;
        oy = H / 2 - 1;
    endtask

    task automatic model_op(int c);
        int a[4];
        int t[4];
        int v[4];
        int m;
        a[0] = oy * W + ox;
        a[1] = a[0] + 1;
        a[2] = a[0] + W;
        a[3] = a[2] + 1;
        for (int k = 0; k < 4; k++) t[k] = img[a[k]];
        v = t;
        case (c)
            1: if (oy > 0) oy--;
            2: if (oy < H - 2) oy++;
            3: if (ox > 0) ox--;
            4: if (ox < W - 2) ox++;
            5: begin
                m = t[0];
                for (int k = 1; k < 4; k++) if (t[k] > m) m = t[k];
                v = '{m, m, m, m};
            end
            6: begin
                m = t[0];
                for (int k = 1; k < 4; k++) if (t[k] < m) m = t[k];
                v = '{m, m, m, m};
            end
            7: begin
                m = (t[0] + t[1] + t[2] + t[3]) / 4;
                v = '{m, m, m, m};
            end
            8:  v = '{t[1], t[3], t[0], t[2]};
            9:  v = '{t[2], t[0], t[3], t[1]};
            10: v = '{t[2], t[3], t[0], t[1]};
            11: v = '{t[1], t[0], t[3], t[2]};
            default: ;
        endcase
        for (int k = 0; k < 4; k++) img[a[k]] = v[k];
    endtask

    task automatic do_op(int c);
        step(mk(1, 0, 0, 0, -1, -1, -1), 1'b1, 4'(c));
        model_op(c);
        step_n(mk(0, 0, 0, 0, -1, -1, -1));
        if ($urandom_range(0, 1) == 1) idle_cycle();
    endtask

    task automatic do_write();
        step(mk(1, 0, 1, 0, -1, 0, img[0]), 1'b1, 4'h0);
        for (int i = 1; i < N; i++) step_n(mk(1, 0, 1, 0, -1, i, img[i]));
        step_n(mk(1, 1, 0, 0, -1, 0, -1));
        step_n(mk(0, 0, 0, 0, -1, -1, -1));
    endtask

    task automatic write_abort(int at);
        step(mk(1, 0, 1, 0, -1, 0, img[0]), 1'b1, 4'h0);
        for (int i = 1; i <= at; i++) step_n(mk(1, 0, 1, 0, -1, i, img[i]));
        reset = 1'b0;
        #1;
        chk("abort_valid", int'(IRAM_valid), 0);
        chk("abort_iram_a", int'(IRAM_A), 0);
        chk("abort_iram_d", int'(IRAM_D), 0);
        chk("abort_busy", int'(busy), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_rd", int'(IROM_rd), 0);
        chk("abort_irom_a", int'(IROM_A), 0);
        reset_load();
    endtask

    initial begin
        int r;
        bit seen;
        total = 0; bad = 0; wr2 = 0;
        reset = 1'b0; cmd = 4'h0; cmd_valid = 1'b0;
        reset2 = 1'b0; cmd2 = 4'h0; cmd_valid2 = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = 8'(i);
        @(negedge clk);
        #1;

        // Plain ramp dump, a no-op command, then an identical second dump.
        reset_load();
        do_write();
        chk("ramp_ram0", ram[0], 0);
        chk("ramp_ram63", ram[63], 63);
        do_op(12);
        do_write();
        chk("ramp2_ram45", ram[45], 45);

        reset_load();
        do_op(5);
        do_write();
        chk("max_27", ram[27], 36);
        chk("max_28", ram[28], 36);
        chk("max_35", ram[35], 36);
        chk("max_36", ram[36], 36);
        chk("max_26", ram[26], 26);

        reset_load();
        do_op(7);
        do_write();
        chk("avg_27", ram[27], 31);
        chk("avg_36", ram[36], 31);

        reset_load();
        repeat (5) do_op(4);
        do_op(8);
        do_write();
        chk("ccw_30", ram[30], 31);
        chk("ccw_31", ram[31], 39);
        chk("ccw_38", ram[38], 30);
        chk("ccw_39", ram[39], 38);
        repeat (7) do_op(3);
        repeat (4) do_op(1);
        do_op(5);
        do_write();
        chk("corner_0", ram[0], 9);
        chk("corner_9", ram[9], 9);

        write_abort(20);
        do_write();
        chk("reload_0", ram[0], 0);

        for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
        reset_load();
        repeat (60) begin
            r = $urandom_range(0, 99);
            if (r < 10) do_write();
            else if (r < 20) idle_cycle();
            else do_op($urandom_range(1, 15));
        end
        do_write();
        cmd_valid = 1'b0;

        // Small 4x4, 12-bit instance: ramp load, max at the reset origin.
        reset2 = 1'b1;
        for (int c = 1; c <= N2 + 2; c++) begin
            @(negedge clk);
            if (c == 1) chk("s_rom_a_first", int'(IROM_A2), 0);
            if (c == N2) chk("s_rom_a_last", int'(IROM_A2), 15);
            if (c == N2 + 1) chk("s_busy_last", int'(busy2), 1);
            if (c == N2 + 2) chk("s_busy_idle", int'(busy2), 0);
        end
        #1;
        cmd_valid2 = 1'b1; cmd2 = 4'h5;
        @(negedge clk); #1;
        cmd_valid2 = 1'b0;
        @(negedge clk); #1;
        cmd_valid2 = 1'b1; cmd2 = 4'h0;
        @(negedge clk); #1;
        cmd_valid2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
        chk("s_done_seen", int'(seen), 1);
        @(negedge clk); #1;
        chk("s_busy_after", int'(busy2), 0);
        chk("s_writes", wr2, 16);
        chk("s_max_5", ram2[5], 10);
        chk("s_max_6", ram2[6], 10);
        chk("s_max_9", ram2[9], 10);
        chk("s_max_10", ram2[10], 10);
        chk("s_ram_0", ram2[0], 0);
        chk("s_ram_15", ram2[15], 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised next-generation LCD image controller.
- Loads a full IMG_W x IMG_H frame from IROM into an internal buffer and applies host commands to a 2x2 operation window.
- On the write command, streams the whole buffer to IRAM, pulses done, then returns to command idle with the buffer retained, so multiple frames can be emitted.
- Sits between the image ROM, the host command interface and the display RAM.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 8, image width in pixels (even, >=4)
- IMG_H, 8, image height in pixels (even, >=4)
- ADDR_W, $clog2(IMG_W*IMG_H), pixel address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cmd  in  4  command opcode
- cmd_valid  in  1  command strobe; sampled only while busy=0
- IROM_Q  in  DATA_W  ROM data for the address presented the previous cycle
- IROM_rd  out  1  ROM read enable
- IROM_A  out  ADDR_W  ROM address
- IRAM_valid  out  1  RAM write strobe
- IRAM_D  out  DATA_W  RAM write data
- IRAM_A  out  ADDR_W  RAM write address
- busy  out  1  high while load, operation or write is in progress
- done  out  1  one-cycle pulse after the last RAM write

Behaviour:
- Reset values (reset=0): IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, busy=1, done=0, state=LOAD, window origin (ox,oy)=(IMG_W/2-1, IMG_H/2-1). Buffer contents are not reset.
- All outputs are registered.
- States: LOAD -> LOAD_LAST -> IDLE -> {OP | WRITE} -> IDLE.
- LOAD:
  - IROM_rd=1; IROM_A steps 0..N-1, where N=IMG_W*IMG_H.
  - buffer[IROM_A(prev)] <= IROM_Q every cycle after the first.
  - At A=N-1, go to LOAD_LAST. LOAD_LAST captures the last pixel, drops IROM_rd and enters IDLE.
  - busy falls on the first IDLE cycle, N+2 cycles after reset release.
- IDLE:
  - busy=0.
  - cmd_valid=1 with cmd=0 -> WRITE.
  - cmd_valid=1 with any other cmd -> OP.
  - busy rises the next cycle.
- OP:
  - Exactly one cycle, busy=1; updates the window or origin, then returns to IDLE.
  - Window pixels: TL=(ox,oy), TR=(ox+1,oy), BL=(ox,oy+1), BR=(ox+1,oy+1). Address = y*IMG_W+x.
- Opcodes:
  - 1 up, 2 down, 3 left, 4 right: move origin by 1. Saturate at 0 and at IMG_W-2 / IMG_H-2; no wrap.
  - 5 max: all four pixels <= max of the four.
  - 6 min: all four pixels <= min of the four.
  - 7 avg: all four pixels <= floor(sum/4). Sum is DATA_W+2 bits; no overflow.
  - 8 CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 9 CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
  - A mirror-X: TL<->BL, TR<->BR.
  - B mirror-Y: TL<->TR, BL<->BR.
  - C-F: no-op. Still one busy cycle; no state change.
- WRITE:
  - IRAM_valid=1 for N consecutive cycles; IRAM_A=0..N-1; IRAM_D=buffer[IRAM_A], aligned in the same cycle.
  - The cycle after the last write: IRAM_valid=0, IRAM_A=0, done=1 for one cycle, busy=1.
  - Next cycle: IDLE, busy=0, done=0.
- cmd_valid while busy=1 is ignored. No queueing.
- reset asserted at any point (mid-load, mid-write) aborts immediately. After release, a full reload starts from IROM_A=0.
- IROM_A and IRAM_A never exceed N-1.

Decomposition:
- Package lcd_ctrl_pkg holds:
  - opcode localparams CMD_WRITE..CMD_MIRY (0..B);
  - state enum LOAD/LOAD_LAST/IDLE/OP/WRITE;
  - N/ADDR_W helper function.
- Sub-module lcd_window_alu: combinational; four DATA_W inputs plus opcode -> four DATA_W outputs (max/min/avg/rotate/mirror).
- The top level keeps the FSM, counters, origin and buffer.

Test Plan:
- Ramp ROM (pixel i=i), 8x8; cmd 0 at first IDLE -> IRAM receives A=0..63, D=0..63, 64 contiguous valid cycles; done high one cycle after A=63; busy low the next cycle.
- Ramp; cmd 5 then cmd 0 -> addresses 27,28,35,36 all =36; every other address unchanged.
- Ramp; cmd 7 then cmd 0 -> addresses 27,28,35,36 all =31 (126/4 floor).
- Ramp; cmd 4 x5, cmd 8, cmd 0 -> origin saturates at x=6; addresses 30,31,38,39 = 31,39,30,38. Then cmd 3 x7, cmd 1 x4 -> origin (0,0), no wrap.
- cmd_valid held during OP and WRITE -> no extra operations. cmd 0xC -> one busy cycle, image unchanged. Second cmd 0 -> identical 64-write stream, done pulses again.
- reset low at IRAM_A=20 -> all outputs at reset values within the same cycle; after release, IROM_A restarts at 0. Repeat the ramp test with IMG_W=4, IMG_H=4, DATA_W=12 -> 16 writes; reset origin (1,1); max over 5,6,9,10 = 10.
